// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU sequencer and its ALU.
package alu_sequencer_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned FLAG_W = 4;

   // Flag-write mask bits, ordered {N,Z,C,V}
   localparam logic [FLAG_W-1:0] FLAG_N = 4'b1000;
   localparam logic [FLAG_W-1:0] FLAG_Z = 4'b0100;
   localparam logic [FLAG_W-1:0] FLAG_C = 4'b0010;
   localparam logic [FLAG_W-1:0] FLAG_V = 4'b0001;

   // BCD correction constants
   localparam logic [DATA_W-1:0] BCD_LO   = 8'h06;
   localparam logic [DATA_W-1:0] BCD_HI   = 8'h60;
   localparam logic [DATA_W-1:0] BCD_BOTH = 8'h66;

   typedef enum logic [2:0] {
      SEQ_ADC = 3'd0,
      SEQ_SBC = 3'd1,
      SEQ_CMP = 3'd2,
      SEQ_ASL = 3'd3,
      SEQ_ROL = 3'd4,
      SEQ_INC = 3'd5,
      SEQ_DEC = 3'd6
   } seq_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      CORR = 2'd2,
      DONE = 2'd3
   } seq_state_t;

   typedef enum logic [1:0] {
      ALU_ADD        = 2'd0,
      ALU_SUB        = 2'd1,
      ALU_SHIFT_LEFT = 2'd2
   } alu_op_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   // Which status flags an op updates
   function automatic logic [FLAG_W-1:0] op_flag_mask(input seq_op_t op);
      logic [FLAG_W-1:0] m;
      case (op)
         SEQ_ADC, SEQ_SBC:          m = FLAG_N | FLAG_Z | FLAG_C | FLAG_V;
         SEQ_CMP, SEQ_ASL, SEQ_ROL: m = FLAG_N | FLAG_Z | FLAG_C;
         SEQ_INC, SEQ_DEC:          m = FLAG_N | FLAG_Z;
         default:                   m = '0;
      endcase
      return m;
   endfunction

   // Decimal correction amount from the low/high nibble adjust decisions
   function automatic logic [DATA_W-1:0] bcd_k(input logic lo, input logic hi);
      logic [DATA_W-1:0] k;
      case ({hi, lo})
         2'b01:   k = BCD_LO;
         2'b10:   k = BCD_HI;
         2'b11:   k = BCD_BOTH;
         default: k = '0;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response bus between the core and the ALU sequencer.
interface alu_sequencer_if;
   import alu_sequencer_pkg::*;

   logic                req_valid;
   logic                req_ready;
   seq_op_t             req_op;
   logic [DATA_W-1:0]   req_a;
   logic [DATA_W-1:0]   req_b;
   logic                req_carry;
   logic                req_decimal;
   logic                flush;
   logic                resp_valid;
   logic                resp_ready;
   logic [DATA_W-1:0]   result;
   logic                result_we;
   logic                flag_n;
   logic                flag_z;
   logic                flag_c;
   logic                flag_v;
   logic [FLAG_W-1:0]   flag_we;

   modport master (
      output req_valid, req_op, req_a, req_b, req_carry, req_decimal, flush, resp_ready,
      input  req_ready, resp_valid, result, result_we, flag_n, flag_z, flag_c, flag_v, flag_we
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_carry, req_decimal, flush, resp_ready,
      output req_ready, resp_valid, result, result_we, flag_n, flag_z, flag_c, flag_v, flag_we
   );

endinterface

// File: rtl/alu_sequencer_alu.sv
// Shared combinational ALU: add with carry, subtract with borrow, shift left.
module alu_sequencer_alu
   import alu_sequencer_pkg::*;
(
   input  alu_op_t            i_op,
   input  logic [DATA_W-1:0]  i_a,
   input  logic [DATA_W-1:0]  i_b,
   input  logic               i_cin,
   output logic [DATA_W-1:0]  o_result_c,
   output logic               o_carry_c
);

   logic [DATA_W:0] w_sum;
   logic [DATA_W:0] w_diff;
   logic [DATA_W:0] w_shl;
   logic            w_shift_nz;

   // Arithmetic and shift candidates; carry out of subtract is no-borrow
   always_comb begin
      w_sum      = {1'b0, i_a} + {1'b0, i_b} + {8'b0, i_cin};
      w_diff     = {1'b0, i_a} - {1'b0, i_b} - {8'b0, ~i_cin};
      w_shl      = {1'b0, i_a} << i_b;
      w_shift_nz = (i_b != '0);
   end

   // Select the requested operation
   always_comb begin
      o_result_c = w_sum[DATA_W-1:0];
      o_carry_c  = w_sum[DATA_W];
      case (i_op)
         ALU_SUB: begin
            o_result_c = w_diff[DATA_W-1:0];
            o_carry_c  = ~w_diff[DATA_W];
         end
         ALU_SHIFT_LEFT: begin
            o_result_c = w_shl[DATA_W-1:0] | {7'b0, w_shift_nz & i_cin};
            o_carry_c  = w_shift_nz & w_shl[DATA_W];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences the shared ALU for arithmetic, compare, shift and inc/dec ops,
// with a second BCD-correction pass for decimal ADC/SBC.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter bit DECIMAL_EN = 1'b1,
   parameter bit CMOS_FLAGS = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_sequencer_if.slave bus
);

   seq_state_t          r_state,     w_state_nxt;
   seq_op_t             r_op,        w_op_nxt;
   logic [DATA_W-1:0]   r_a,         w_a_nxt;
   logic [DATA_W-1:0]   r_b,         w_b_nxt;
   logic                r_carry,     w_carry_nxt;
   logic                r_dec,       w_dec_nxt;
   logic [DATA_W-1:0]   r_result,    w_result_nxt;
   flags_t              r_flags,     w_flags_nxt;
   logic                r_result_we, w_result_we_nxt;
   logic [FLAG_W-1:0]   r_flag_we,   w_flag_we_nxt;
   logic                r_resp_valid, w_resp_valid_nxt;
   logic                r_ready,     w_ready_nxt;
   logic [DATA_W-1:0]   r_k,         w_k_nxt;
   logic                r_c_corr,    w_c_corr_nxt;

   alu_op_t             w_alu_op;
   logic [DATA_W-1:0]   w_alu_a;
   logic [DATA_W-1:0]   w_alu_b;
   logic                w_alu_cin;
   logic [DATA_W-1:0]   w_alu_res;
   logic                w_alu_cout;

   logic                w_accept;
   logic                w_v;
   logic [4:0]          w_lo_sum;
   logic [4:0]          w_lo_need;
   logic                w_lo_adj;
   logic                w_hi_adj;
   logic [DATA_W-1:0]   w_k;
   logic                w_c_corr;

   assign w_accept = bus.req_valid & bus.req_ready;

   assign bus.req_ready  = r_ready & ~bus.flush;
   assign bus.resp_valid = r_resp_valid;
   assign bus.result     = r_result;
   assign bus.result_we  = r_result_we;
   assign bus.flag_n     = r_flags.n;
   assign bus.flag_z     = r_flags.z;
   assign bus.flag_c     = r_flags.c;
   assign bus.flag_v     = r_flags.v;
   assign bus.flag_we    = r_flag_we;

   alu_sequencer_alu u_alu (
      .i_op       (w_alu_op),
      .i_a        (w_alu_a),
      .i_b        (w_alu_b),
      .i_cin      (w_alu_cin),
      .o_result_c (w_alu_res),
      .o_carry_c  (w_alu_cout)
   );

   // ALU input mux: op mapping in EXEC, correction pass in CORR
   always_comb begin
      w_alu_op  = ALU_ADD;
      w_alu_a   = r_a;
      w_alu_b   = r_b;
      w_alu_cin = r_carry;
      if (r_state == CORR) begin
         w_alu_a = r_result;
         w_alu_b = r_k;
         if (r_op == SEQ_SBC) begin
            w_alu_op  = ALU_SUB;
            w_alu_cin = 1'b1;
         end else begin
            w_alu_op  = ALU_ADD;
            w_alu_cin = 1'b0;
         end
      end else begin
         case (r_op)
            SEQ_SBC: w_alu_op = ALU_SUB;
            SEQ_CMP: begin
               w_alu_op  = ALU_SUB;
               w_alu_cin = 1'b1;
            end
            SEQ_ASL: begin
               w_alu_op  = ALU_SHIFT_LEFT;
               w_alu_b   = 8'd1;
               w_alu_cin = 1'b0;
            end
            SEQ_ROL: begin
               w_alu_op  = ALU_SHIFT_LEFT;
               w_alu_b   = 8'd1;
            end
            SEQ_INC: begin
               w_alu_b   = 8'd1;
               w_alu_cin = 1'b0;
            end
            SEQ_DEC: begin
               w_alu_op  = ALU_SUB;
               w_alu_b   = 8'd1;
               w_alu_cin = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Overflow from the binary pass, and BCD correction amount / decimal carry
   always_comb begin
      w_v = 1'b0;
      if (r_op == SEQ_ADC)
         w_v = (r_a[7] ^ w_alu_res[7]) & (w_alu_b[7] ^ w_alu_res[7]);
      else if (r_op == SEQ_SBC)
         w_v = (r_a[7] ^ w_alu_b[7]) & (r_a[7] ^ w_alu_res[7]);

      w_lo_sum  = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0, r_carry};
      w_lo_need = {1'b0, r_b[3:0]} + {4'b0, ~r_carry};
      if (r_op == SEQ_SBC) begin
         w_lo_adj = ({1'b0, r_a[3:0]} < w_lo_need);
         w_hi_adj = ~w_alu_cout;
         w_c_corr = w_alu_cout;
      end else begin
         w_lo_adj = (w_lo_sum > 5'd9);
         w_hi_adj = w_alu_cout | (w_alu_res > 8'h99);
         w_c_corr = w_hi_adj;
      end
      w_k = bcd_k(w_lo_adj, w_hi_adj);
   end

   // Next state and next register values
   always_comb begin
      w_state_nxt      = r_state;
      w_op_nxt         = r_op;
      w_a_nxt          = r_a;
      w_b_nxt          = r_b;
      w_carry_nxt      = r_carry;
      w_dec_nxt        = r_dec;
      w_result_nxt     = r_result;
      w_flags_nxt      = r_flags;
      w_result_we_nxt  = r_result_we;
      w_flag_we_nxt    = r_flag_we;
      w_resp_valid_nxt = r_resp_valid;
      w_k_nxt          = r_k;
      w_c_corr_nxt     = r_c_corr;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_op_nxt    = bus.req_op;
               w_a_nxt     = bus.req_a;
               w_b_nxt     = bus.req_b;
               w_carry_nxt = bus.req_carry;
               w_dec_nxt   = DECIMAL_EN & bus.req_decimal &
                             ((bus.req_op == SEQ_ADC) | (bus.req_op == SEQ_SBC));
               w_state_nxt = EXEC;
            end
         end
         EXEC: begin
            w_result_nxt    = w_alu_res;
            w_flags_nxt     = '{n: w_alu_res[7], z: (w_alu_res == '0), c: w_alu_cout, v: w_v};
            w_result_we_nxt = (r_op != SEQ_CMP);
            w_flag_we_nxt   = op_flag_mask(r_op);
            w_k_nxt         = w_k;
            w_c_corr_nxt    = w_c_corr;
            if (r_dec) begin
               w_state_nxt = CORR;
            end else begin
               w_state_nxt      = DONE;
               w_resp_valid_nxt = 1'b1;
            end
         end
         CORR: begin
            w_result_nxt  = w_alu_res;
            w_flags_nxt.c = r_c_corr;
            if (CMOS_FLAGS) begin
               w_flags_nxt.n = w_alu_res[7];
               w_flags_nxt.z = (w_alu_res == '0);
            end
            w_state_nxt      = DONE;
            w_resp_valid_nxt = 1'b1;
         end
         DONE: begin
            if (bus.resp_ready) begin
               w_state_nxt      = IDLE;
               w_resp_valid_nxt = 1'b0;
               w_result_we_nxt  = 1'b0;
               w_flag_we_nxt    = '0;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      // Flush abandons whatever is in flight without a response
      if (bus.flush) begin
         w_state_nxt      = IDLE;
         w_resp_valid_nxt = 1'b0;
         w_result_we_nxt  = 1'b0;
         w_flag_we_nxt    = '0;
      end

      w_ready_nxt = (w_state_nxt == IDLE);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_op         <= SEQ_ADC;
         r_a          <= '0;
         r_b          <= '0;
         r_carry      <= 1'b0;
         r_dec        <= 1'b0;
         r_result     <= '0;
         r_flags      <= '0;
         r_result_we  <= 1'b0;
         r_flag_we    <= '0;
         r_resp_valid <= 1'b0;
         r_ready      <= 1'b0;
         r_k          <= '0;
         r_c_corr     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_op         <= w_op_nxt;
         r_a          <= w_a_nxt;
         r_b          <= w_b_nxt;
         r_carry      <= w_carry_nxt;
         r_dec        <= w_dec_nxt;
         r_result     <= w_result_nxt;
         r_flags      <= w_flags_nxt;
         r_result_we  <= w_result_we_nxt;
         r_flag_we    <= w_flag_we_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_ready      <= w_ready_nxt;
         r_k          <= w_k_nxt;
         r_c_corr     <= w_c_corr_nxt;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed ops, backpressure, flush, reset.
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   alu_sequencer_if bus();

   alu_sequencer #(.DECIMAL_EN(1'b1), .CMOS_FLAGS(1'b0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  res;
      logic        we;
      logic [3:0]  flg;   // {N,Z,C,V}
      logic [3:0]  fwe;
      logic [3:0]  lat;
      logic [31:0] acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic prev_valid = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: latency on rising resp_valid, contents on each handshake
   always @(negedge clk) begin
      exp_t e;
      if (bus.resp_valid && !prev_valid && sb.size() > 0)
         chk("latency", 32'(cyc) - sb[0].acc, 32'(sb[0].lat));
      if (bus.resp_valid && bus.resp_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp actual=%0h required=none", bus.result);
         end else begin
            e = sb.pop_front();
            chk("result",    32'(bus.result),    32'(e.res));
            chk("result_we", 32'(bus.result_we), 32'(e.we));
            chk("flag_we",   32'(bus.flag_we),   32'(e.fwe));
            chk("flags",     32'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v} & e.fwe),
                             32'(e.flg & e.fwe));
         end
      end
      prev_valid = bus.resp_valid;
   end

   task automatic send(input seq_op_t op, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic d, input logic [7:0] res, input logic we,
                       input logic [3:0] flg, input logic [3:0] fwe, input logic [3:0] lat,
                       input bit push);
      int n = 0;
      exp_t e;
      while (!bus.req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.req_ready) begin
         checks++;
         errors++;
         $display("FAIL req_ready_timeout actual=0 required=1");
         return;
      end
      bus.req_op      = op;
      bus.req_a       = a;
      bus.req_b       = b;
      bus.req_carry   = c;
      bus.req_decimal = d;
      bus.req_valid   = 1'b1;
      @(posedge clk); #1;
      bus.req_valid   = 1'b0;
      bus.req_a       = 8'($urandom);
      bus.req_b       = 8'($urandom);
      bus.req_carry   = 1'($urandom);
      bus.req_decimal = 1'($urandom);
      if (push) begin
         e = '{res: res, we: we, flg: flg, fwe: fwe, lat: lat, acc: 32'(cyc)};
         sb.push_back(e);
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() > 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d required=0", sb.size());
      end
   endtask

   initial begin
      int n;
      bus.req_valid   = 1'b0;
      bus.req_op      = SEQ_ADC;
      bus.req_a       = '0;
      bus.req_b       = '0;
      bus.req_carry   = 1'b0;
      bus.req_decimal = 1'b0;
      bus.flush       = 1'b0;
      bus.resp_ready  = 1'b1;

      // Reset values
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready",  32'(bus.req_ready),  32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_result",     32'(bus.result),     32'd0);
      chk("rst_flag_we",    32'(bus.flag_we),    32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

      //    op       a      b      C     D     res    we    NZCV     mask     lat
      send(SEQ_ADC, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 1'b1, 4'b1001, 4'b1111, 4'd1, 1'b1);
      send(SEQ_ADC, 8'h58, 8'h46, 1'b1, 1'b1, 8'h05, 1'b1, 4'b1011, 4'b1111, 4'd2, 1'b1);
      send(SEQ_ADC, 8'h58, 8'h46, 1'b1, 1'b0, 8'h9F, 1'b1, 4'b1001, 4'b1111, 4'd1, 1'b1);
      send(SEQ_SBC, 8'h12, 8'h21, 1'b1, 1'b1, 8'h91, 1'b1, 4'b1000, 4'b1111, 4'd2, 1'b1);
      send(SEQ_ADC, 8'h99, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 4'b1010, 4'b1111, 4'd2, 1'b1);
      send(SEQ_SBC, 8'h10, 8'h01, 1'b1, 1'b1, 8'h09, 1'b1, 4'b0010, 4'b1111, 4'd2, 1'b1);
      send(SEQ_SBC, 8'h50, 8'hF0, 1'b1, 1'b0, 8'h60, 1'b1, 4'b0000, 4'b1111, 4'd1, 1'b1);
      send(SEQ_CMP, 8'h05, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0110, 4'b1110, 4'd1, 1'b1);
      send(SEQ_ROL, 8'hC3, 8'h00, 1'b1, 1'b0, 8'h87, 1'b1, 4'b1010, 4'b1110, 4'd1, 1'b1);
      send(SEQ_ASL, 8'h80, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 4'b0110, 4'b1110, 4'd1, 1'b1);
      send(SEQ_DEC, 8'h00, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b1, 4'b1000, 4'b1100, 4'd1, 1'b1);
      send(SEQ_INC, 8'hFF, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 4'b0100, 4'b1100, 4'd1, 1'b1);
      wait_drain();

      // Backpressure: response held while resp_ready low
      bus.resp_ready = 1'b0;
      send(SEQ_ADC, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b1, 4'b0000, 4'b1111, 4'd1, 1'b1);
      n = 0;
      while (!bus.resp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("hold_valid",  32'(bus.resp_valid), 32'd1);
         chk("hold_result", 32'(bus.result),     32'h03);
         chk("hold_ready",  32'(bus.req_ready),  32'd0);
      end
      bus.resp_ready = 1'b1;
      wait_drain();

      // Flush during the correction pass: no response
      send(SEQ_ADC, 8'h58, 8'h46, 1'b1, 1'b1, 8'h00, 1'b1, 4'b0000, 4'b1111, 4'd2, 1'b0);
      @(posedge clk); #1;
      bus.flush = 1'b1;
      bus.req_valid = 1'b1;
      #1;
      chk("flush_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      bus.flush = 1'b0;
      bus.req_valid = 1'b0;
      chk("flush_valid", 32'(bus.resp_valid), 32'd0);
      @(posedge clk); #1;
      chk("flush_valid2", 32'(bus.resp_valid), 32'd0);
      chk("flush_idle",   32'(bus.req_ready),  32'd1);

      // Async reset while in EXEC
      send(SEQ_ADC, 8'h50, 8'h50, 1'b0, 1'b0, 8'h00, 1'b1, 4'b0000, 4'b1111, 4'd1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("exec_rst_valid",  32'(bus.resp_valid), 32'd0);
      chk("exec_rst_result", 32'(bus.result),     32'd0);
      chk("exec_rst_flags",  32'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 32'd0);
      chk("exec_rst_we",     32'({bus.result_we, bus.flag_we}), 32'd0);
      chk("exec_rst_ready",  32'(bus.req_ready),  32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("exec_rst_release", 32'(bus.req_ready), 32'd1);

      // Recovery after reset
      send(SEQ_INC, 8'h7F, 8'h00, 1'b0, 1'b0, 8'h80, 1'b1, 4'b1000, 4'b1100, 4'd1, 1'b1);
      wait_drain();
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
